// File: rtl/adc_seq_pkg.sv
// Shared types for the modular-ADC sequencer.
// When ADC_SEQ_TSTAMP_EN is defined, buffered samples carry a 16-bit timestamp.
package adc_seq_pkg;
    localparam int CH_W   = 5;
    localparam int DATA_W = 12;
    localparam int TS_W   = 16;

    typedef logic [CH_W-1:0]   chan_t;
    typedef logic [DATA_W-1:0] sample_t;

    typedef struct packed {
        chan_t chan;
        logic  first;
        logic  last;
    } exp_t;

    typedef struct packed {
`ifdef ADC_SEQ_TSTAMP_EN
        logic [TS_W-1:0] tstamp;
`endif
        chan_t   chan;
        logic    first;
        logic    last;
        sample_t data;
    } smp_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/adc_seq_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Used both as the in-flight expect queue and as the sample buffer.
module adc_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign rd_valid = (count != '0);
    assign do_push  = push && (count != CW'(DEPTH));
    assign do_pop   = pop && rd_valid;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // NOTE: registers update with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; rd_data is masked while empty so no stale word escapes.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/adc_seq_ctrl.sv
// Command/response sequencer for the modular ADC with credit-limited issue and sample buffering.
// Define ADC_SEQ_TSTAMP_EN to add the sample_tstamp output.
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int                     NUM_CH     = 4,
    parameter logic [NUM_CH*CH_W-1:0] CH_LIST    = {5'd3, 5'd2, 5'd1, 5'd0},
    parameter int                     MAX_OUTST  = 4,
    parameter int                     FIFO_DEPTH = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] burst_len,
    output logic        busy,
    output logic        command_valid,
    output logic [4:0]  command_channel,
    output logic        command_startofpacket,
    output logic        command_endofpacket,
    input  logic        command_ready,
    input  logic        response_valid,
    input  logic [4:0]  response_channel,
    input  logic [11:0] response_data,
    input  logic        response_startofpacket,
    input  logic        response_endofpacket,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [11:0] sample_data,
    output logic [4:0]  sample_channel,
    output logic        sample_first,
    output logic        sample_last,
`ifdef ADC_SEQ_TSTAMP_EN
    output logic [15:0] sample_tstamp,
`endif
    output logic        err_chan_mismatch,
    output logic        err_unexpected
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OW    = $clog2(MAX_OUTST) + 1;
    localparam int FW    = $clog2(FIFO_DEPTH) + 1;
    localparam int SW    = FW + 1;

    state_e           state, state_next;
    logic [IDX_W-1:0] ch_idx;
    logic [15:0]      frame_cnt, burst_len_q;
    logic             stop_lat, err_chan_q, err_unexp_q;
    logic [OW-1:0]    outst;
    logic [FW-1:0]    fifo_count;
    logic [SW-1:0]    credit_used;
    logic             exp_valid, credit_ok, is_eop, end_burst;
    logic             accept, rsp_ok, start_ok;
    chan_t            cur_chan;
    exp_t             exp_head, exp_push;
    smp_t             smp_head, smp_push;
    logic             unused_ok;

    assign unused_ok   = &{1'b0, response_startofpacket, response_endofpacket};

    // Every issued command reserves a sample slot, so responses can never overflow the buffer.
    assign credit_used = SW'(fifo_count) + SW'(outst);
    assign credit_ok   = (outst < OW'(MAX_OUTST)) && (credit_used < SW'(FIFO_DEPTH));
    assign is_eop      = (ch_idx == IDX_W'(NUM_CH - 1));
    assign end_burst   = stop_lat || stop ||
                         ((burst_len_q != 16'd0) && (frame_cnt == burst_len_q - 16'd1));
    assign cur_chan    = CH_LIST[CH_W*int'(ch_idx) +: CH_W];
    assign start_ok    = (state == IDLE) && start;
    assign accept      = command_valid && command_ready;
    assign rsp_ok      = response_valid && exp_valid;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_next;
    end

    // NOTE: defaults first keep this block free of latches.
    always_comb begin
        state_next    = state;
        command_valid = 1'b0;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                command_valid = credit_ok;
                if (credit_ok && command_ready && is_eop && end_burst) state_next = DRAIN;
            end
            DRAIN:   if (outst == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || start_ok) begin
            ch_idx      <= '0;
            frame_cnt   <= '0;
            burst_len_q <= reset_reset ? 16'd0 : burst_len;
            stop_lat    <= 1'b0;
            err_chan_q  <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            if (accept) begin
                ch_idx <= is_eop ? '0 : ch_idx + IDX_W'(1);
                if (is_eop) frame_cnt <= frame_cnt + 16'd1;
            end
            if (state == RUN && stop) stop_lat <= 1'b1;
            if (rsp_ok && (response_channel != exp_head.chan)) err_chan_q <= 1'b1;
            if (response_valid && !exp_valid) err_unexp_q <= 1'b1;
        end
    end

`ifdef ADC_SEQ_TSTAMP_EN
    logic [TS_W-1:0] tstamp_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset || start_ok) tstamp_q <= '0;
        else                         tstamp_q <= tstamp_q + TS_W'(1);
    end

    assign sample_tstamp = smp_head.tstamp;
`endif

    assign exp_push = '{chan: cur_chan, first: (ch_idx == '0), last: is_eop};

    always_comb begin
        smp_push       = '0;
        smp_push.chan  = response_channel;
        smp_push.first = exp_head.first;
        smp_push.last  = exp_head.last;
        smp_push.data  = response_data;
`ifdef ADC_SEQ_TSTAMP_EN
        smp_push.tstamp = tstamp_q;
`endif
    end

    adc_seq_fifo #(.WIDTH($bits(exp_t)), .DEPTH(MAX_OUTST)) u_expect (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .push      (accept),
        .push_data (exp_push),
        .pop       (rsp_ok),
        .rd_valid  (exp_valid),
        .rd_data   (exp_head),
        .count     (outst)
    );

    adc_seq_fifo #(.WIDTH($bits(smp_t)), .DEPTH(FIFO_DEPTH)) u_samples (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .push      (rsp_ok),
        .push_data (smp_push),
        .pop       (sample_ready),
        .rd_valid  (sample_valid),
        .rd_data   (smp_head),
        .count     (fifo_count)
    );

    assign busy                  = (state != IDLE);
    assign command_channel       = command_valid ? cur_chan : '0;
    assign command_startofpacket = command_valid && (ch_idx == '0);
    assign command_endofpacket   = command_valid && is_eop;
    assign sample_data           = smp_head.data;
    assign sample_channel        = smp_head.chan;
    assign sample_first          = smp_head.first;
    assign sample_last           = smp_head.last;
    assign err_chan_mismatch     = err_chan_q;
    assign err_unexpected        = err_unexp_q;
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: ADC model with 3-cycle echo latency, per-cycle reference checks
// and directed scenarios with literal expectations.
module tb_adc_seq_ctrl;
    localparam int NUM_CH = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset, start, stop;
    logic [15:0] burst_len;
    logic        busy, command_valid, command_startofpacket, command_endofpacket, command_ready;
    logic [4:0]  command_channel, response_channel, sample_channel;
    logic        response_valid, response_startofpacket, response_endofpacket;
    logic [11:0] response_data, sample_data;
    logic        sample_valid, sample_ready, sample_first, sample_last;
    logic        err_chan_mismatch, err_unexpected;
`ifdef ADC_SEQ_TSTAMP_EN
    logic [15:0] sample_tstamp;
`endif

    adc_seq_ctrl dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start), .stop(stop),
        .burst_len(burst_len), .busy(busy), .command_valid(command_valid),
        .command_channel(command_channel), .command_startofpacket(command_startofpacket),
        .command_endofpacket(command_endofpacket), .command_ready(command_ready),
        .response_valid(response_valid), .response_channel(response_channel),
        .response_data(response_data), .response_startofpacket(response_startofpacket),
        .response_endofpacket(response_endofpacket), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_data(sample_data), .sample_channel(sample_channel),
        .sample_first(sample_first), .sample_last(sample_last),
`ifdef ADC_SEQ_TSTAMP_EN
        .sample_tstamp(sample_tstamp),
`endif
        .err_chan_mismatch(err_chan_mismatch), .err_unexpected(err_unexpected)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct { int chan; int data; bit first; bit last; int ts; } smp_m_t;
    typedef struct { int chan; bit first; bit last; } cmd_m_t;
    typedef struct { int due; int chan; } rsp_m_t;

    int     total = 0, bad = 0, cyc = 0;
    int     ch_tab [NUM_CH] = '{0, 1, 2, 3};
    smp_m_t exp_q[$], got[$];
    cmd_m_t inflight[$];
    rsp_m_t adc_q[$];
    int     acc_log[$];
    int     acc_cnt = 0, n_acc = 0, ts_base = 0;
    bit     m_err_chan = 0, m_err_unexp = 0, corrupt_ch1 = 0, prev_hold = 0;

    int exp_ch   [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_data [8] = '{'h100, 'h101, 'h102, 'h103, 'h100, 'h101, 'h102, 'h103};
    int exp_first[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    int exp_last [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk); #1;
    endtask

    task automatic at_sample();
        @(negedge clk_clk); #1;
    endtask

    task automatic do_start(input logic [15:0] len);
        tick();
        start = 1'b1; burst_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            at_sample();
            if (!busy && !sample_valid && adc_q.size() == 0) break;
        end
        check(name, {31'd0, busy || sample_valid}, 32'd0);
    endtask

    task automatic wait_acc(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            at_sample();
            if (n_acc >= n) break;
        end
        check(name, {31'd0, n_acc >= n}, 32'd1);
    endtask

    initial forever begin
        @(posedge clk_clk);
        cyc++;
    end

    // ADC model: echoes each accepted command 3 cycles later, data = 0x100 + channel.
    initial begin
        rsp_m_t r;
        forever begin
            @(posedge clk_clk); #1;
            response_valid = 1'b0; response_channel = '0; response_data = '0;
            if (adc_q.size() != 0 && adc_q[0].due == cyc) begin
                r = adc_q.pop_front();
                response_valid   = 1'b1;
                response_channel = 5'(r.chan);
                response_data    = 12'(32'h100 + r.chan);
            end
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        int     idx, rch;
        cmd_m_t c;
        smp_m_t s;
        forever begin
            @(negedge clk_clk);
            if (reset_reset) begin
                inflight.delete(); exp_q.delete();
                m_err_chan = 0; m_err_unexp = 0; acc_cnt = 0; ts_base = cyc; prev_hold = 0;
            end else begin
                check("err_chan_mismatch", {31'd0, err_chan_mismatch}, {31'd0, m_err_chan});
                check("err_unexpected", {31'd0, err_unexpected}, {31'd0, m_err_unexp});
                if (start && !busy) begin
                    m_err_chan = 0; m_err_unexp = 0; acc_cnt = 0; ts_base = cyc;
                end
                if (prev_hold) check("cmd_held", {31'd0, command_valid}, 32'd1);
                idx = acc_cnt % NUM_CH;
                if (command_valid) begin
                    check("cmd_chan", 32'(command_channel), ch_tab[idx]);
                    check("cmd_sop", {31'd0, command_startofpacket}, {31'd0, idx == 0});
                    check("cmd_eop", {31'd0, command_endofpacket}, {31'd0, idx == NUM_CH-1});
                    check("cmd_credit", {31'd0, inflight.size() < 4 &&
                          exp_q.size() + inflight.size() < 16}, 32'd1);
                end
                prev_hold = command_valid && !command_ready;
                if (command_valid && command_ready) begin
                    c.chan = ch_tab[idx]; c.first = (idx == 0); c.last = (idx == NUM_CH-1);
                    inflight.push_back(c);
                    acc_log.push_back(c.chan);
                    rch = c.chan;
                    if (corrupt_ch1 && c.chan == 1) begin rch = 2; corrupt_ch1 = 0; end
                    adc_q.push_back('{cyc + 3, rch});
                    acc_cnt++; n_acc++;
                end
                check("smp_valid", {31'd0, sample_valid}, {31'd0, exp_q.size() != 0});
                if (sample_valid && exp_q.size() != 0) begin
                    check("smp_data", 32'(sample_data), exp_q[0].data);
                    check("smp_chan", 32'(sample_channel), exp_q[0].chan);
                    check("smp_first", {31'd0, sample_first}, {31'd0, exp_q[0].first});
                    check("smp_last", {31'd0, sample_last}, {31'd0, exp_q[0].last});
`ifdef ADC_SEQ_TSTAMP_EN
                    check("smp_tstamp", 32'(sample_tstamp), exp_q[0].ts);
`endif
                    if (sample_ready) begin
                        void'(exp_q.pop_front());
                        got.push_back('{int'(sample_channel), int'(sample_data),
                                        sample_first, sample_last, 0});
                    end
                end
                if (response_valid) begin
                    if (inflight.size() != 0) begin
                        c = inflight.pop_front();
                        if (c.chan != int'(response_channel)) m_err_chan = 1;
                        s.chan = response_channel; s.data = response_data;
                        s.first = c.first; s.last = c.last;
                        s.ts = (cyc - ts_base - 1) & 'hFFFF;
                        exp_q.push_back(s);
                    end else begin
                        m_err_unexp = 1;
                    end
                end
            end
        end
    end

    initial begin
        reset_reset = 1'b1; start = 1'b0; stop = 1'b0; burst_len = '0;
        command_ready = 1'b1; sample_ready = 1'b1;
        response_startofpacket = 1'b0; response_endofpacket = 1'b0;
        repeat (3) tick();
        reset_reset = 1'b0;
        at_sample();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_valid", {31'd0, command_valid}, 32'd0);
        check("rst_smp_valid", {31'd0, sample_valid}, 32'd0);

        // Two-frame burst with free-flowing handshakes.
        got.delete(); acc_log.delete(); n_acc = 0;
        do_start(16'd2);
        wait_idle("t1_idle", 200);
        check("t1_cmds", n_acc, 8);
        check("t1_samples", got.size(), 8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++) check("t1_cmd_ch", acc_log[i], exp_ch[i]);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            check("t1_data", got[i].data, exp_data[i]);
            check("t1_chan", got[i].chan, exp_ch[i]);
            check("t1_first", {31'd0, got[i].first}, exp_first[i]);
            check("t1_last", {31'd0, got[i].last}, exp_last[i]);
        end

        // Command backpressure: first command must hold steady.
        command_ready = 1'b0; got.delete(); n_acc = 0;
        do_start(16'd1);
        for (int i = 0; i < 20; i++) begin
            if (command_valid) break;
            at_sample();
        end
        check("t2_valid", {31'd0, command_valid}, 32'd1);
        repeat (5) begin
            check("t2_chan", 32'(command_channel), 32'd0);
            check("t2_sop", {31'd0, command_startofpacket}, 32'd1);
            at_sample();
        end
        check("t2_no_accept", n_acc, 0);
        tick();
        command_ready = 1'b1;
        wait_idle("t2_idle", 200);
        check("t2_samples", got.size(), 4);

        // Sample backpressure in continuous mode: issue stops at 16 reserved credits.
        sample_ready = 1'b0; got.delete(); n_acc = 0;
        do_start(16'd0);
        repeat (60) at_sample();
        check("t3_stall_acc", n_acc, 16);
        check("t3_stall_valid", {31'd0, command_valid}, 32'd0);
        check("t3_full", {31'd0, sample_valid}, 32'd1);
        tick();
        sample_ready = 1'b1;
        repeat (10) at_sample();
        check("t3_resume", {31'd0, n_acc > 16}, 32'd1);
        tick(); stop = 1'b1; tick(); stop = 1'b0;
        wait_idle("t3_idle", 400);
        check("t3_no_loss", got.size(), n_acc);
        check("t3_whole_frames", n_acc % 4, 0);

        // Channel mismatch: ADC answers ch2 for the ch1 command.
        corrupt_ch1 = 1; got.delete(); n_acc = 0;
        do_start(16'd1);
        wait_idle("t4_idle", 200);
        check("t4_samples", got.size(), 4);
        if (got.size() > 1) begin
            check("t4_chan", got[1].chan, 2);
            check("t4_data", got[1].data, 'h102);
        end
        check("t4_err", {31'd0, err_chan_mismatch}, 32'd1);

        // Stop right after ch1 is accepted: the frame still completes.
        got.delete(); n_acc = 0;
        do_start(16'd0);
        wait_acc("t5_ch1", 2, 50);
        tick(); stop = 1'b1; tick(); stop = 1'b0;
        wait_idle("t5_idle", 200);
        check("t5_cmds", n_acc, 4);
        check("t5_samples", got.size(), 4);
        check("t5_err_clear", {31'd0, err_chan_mismatch}, 32'd0);

        // Reset mid-burst, late responses, then a clean burst.
        n_acc = 0;
        do_start(16'd0);
        wait_acc("t6_run", 3, 50);
        tick(); reset_reset = 1'b1;
        tick(); reset_reset = 1'b0;
        at_sample();
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_cmd_valid", {31'd0, command_valid}, 32'd0);
        check("t6_cmd_chan", 32'(command_channel), 32'd0);
        check("t6_cmd_sop_eop", {30'd0, command_startofpacket, command_endofpacket}, 32'd0);
        check("t6_smp", {13'd0, sample_valid, sample_data, sample_channel, sample_first, sample_last}, 32'd0);
        check("t6_errs", {30'd0, err_chan_mismatch, err_unexpected}, 32'd0);
        repeat (6) at_sample();
        check("t6_late_rsp", {31'd0, err_unexpected}, 32'd1);
        got.delete(); n_acc = 0;
        do_start(16'd1);
        wait_idle("t6_idle", 200);
        check("t6_clean_samples", got.size(), 4);
        check("t6_clean_errs", {30'd0, err_chan_mismatch, err_unexpected}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
